// File: rtl/strip_pkg.sv
// Shared types and widths for the LED strip frame scheduler.
package strip_pkg;
  localparam int NUM_CHANNELS = 4;
  localparam int CH_W         = 2;
  localparam int IDX_W        = 7;
  localparam int LIDX_W       = 8;
  localparam int ADDR_W       = 9;
  localparam int PIXEL_W      = 24;

  typedef enum logic [1:0] {IDLE, ARB, WAIT, GAP} state_e;
  typedef logic [LIDX_W-1:0] lidx_t;
endpackage

// File: rtl/strip_scheduler_rr_arbiter4.sv
// Combinational 4-way round-robin arbiter: first set request at or above ptr_i, wrapping.
module rr_arbiter4
  import strip_pkg::*;
(
  input  logic [NUM_CHANNELS-1:0] req_i,
  input  logic [CH_W-1:0]         ptr_i,
  output logic [NUM_CHANNELS-1:0] gnt_o,
  output logic [CH_W-1:0]         idx_o,
  output logic                    vld_o
);
  logic [CH_W-1:0] c;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    c     = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      c = ptr_i + CH_W'(i);
      if (!vld_o && req_i[c]) begin
        vld_o    = 1'b1;
        idx_o    = c;
        gnt_o[c] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/strip_scheduler.sv
// Frame refresh sequencer for four LED strip channels sharing one memory read port.
// Optional STRIP_SCHEDULER_CHANNEL_MASK_EN adds a per-frame channel_enable mask.
module strip_scheduler
  import strip_pkg::*;
#(
  parameter int LED_COUNT    = 128,
  parameter int RESET_CYCLES = 1000,
  parameter int READ_TIMEOUT = 15
) (
  input  logic                    clock_12mhz,
  input  logic                    reset_n,
  input  logic                    framerate,
  input  logic [NUM_CHANNELS-1:0] encoder_finished,
  input  logic                    read_data_ready,
  input  logic [PIXEL_W-1:0]      read_data,
`ifdef STRIP_SCHEDULER_CHANNEL_MASK_EN
  input  logic [NUM_CHANNELS-1:0] channel_enable,
`endif
  output logic                    perform_read,
  output logic [ADDR_W-1:0]       read_address,
  output logic [PIXEL_W-1:0]      encoder_data,
  output logic [NUM_CHANNELS-1:0] encoder_load,
  output logic                    frame_active,
  output logic                    overrun,
  output logic                    read_error
);
  localparam int    TMR_W = $clog2(READ_TIMEOUT + 1);
  localparam int    GAP_W = $clog2(RESET_CYCLES + 1);
  localparam lidx_t LED_N = lidx_t'(LED_COUNT);

  state_e                          state_q;
  logic [NUM_CHANNELS-1:0][LIDX_W-1:0] lidx_q;
  logic [NUM_CHANNELS-1:0]         ch_idle_q, cur_oh_q, encoder_load_q;
  logic [CH_W-1:0]                 rr_ptr_q, cur_q;
  logic [TMR_W-1:0]                tmr_q;
  logic [GAP_W-1:0]                gap_q;
  logic                            perform_read_q, frame_active_q, overrun_q, read_error_q;
  logic [ADDR_W-1:0]               read_address_q;
  logic [PIXEL_W-1:0]              encoder_data_q;

  logic [NUM_CHANNELS-1:0] en, req, done_ch, gnt;
  logic [CH_W-1:0]         gnt_idx;
  logic                    gnt_vld, all_done;

`ifdef STRIP_SCHEDULER_CHANNEL_MASK_EN
  logic [NUM_CHANNELS-1:0] en_q;
  assign en = en_q;
`else
  assign en = '1;
`endif

  // Disabled channels count as complete so the frame can still close.
  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    assign req[c]     = en[c] & ch_idle_q[c] & (lidx_q[c] < LED_N);
    assign done_ch[c] = ~en[c] | (lidx_q[c] == LED_N);
  end
  assign all_done = (&done_ch) & (&ch_idle_q);

  rr_arbiter4 u_arb (
    .req_i (req),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .vld_o (gnt_vld)
  );

  always_ff @(posedge clock_12mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      lidx_q         <= '0;
      ch_idle_q      <= '1;
      cur_oh_q       <= '0;
      cur_q          <= '0;
      rr_ptr_q       <= '0;
      tmr_q          <= '0;
      gap_q          <= '0;
      perform_read_q <= 1'b0;
      read_address_q <= '0;
      encoder_data_q <= '0;
      encoder_load_q <= '0;
      frame_active_q <= 1'b0;
      overrun_q      <= 1'b0;
      read_error_q   <= 1'b0;
`ifdef STRIP_SCHEDULER_CHANNEL_MASK_EN
      en_q           <= '0;
`endif
    end else begin
      perform_read_q <= 1'b0;
      encoder_load_q <= '0;
      ch_idle_q      <= ch_idle_q | encoder_finished;
      if (framerate && state_q != IDLE) overrun_q <= 1'b1;
      case (state_q)
        IDLE: if (framerate) begin
          state_q        <= ARB;
          frame_active_q <= 1'b1;
          lidx_q         <= '0;
`ifdef STRIP_SCHEDULER_CHANNEL_MASK_EN
          en_q           <= channel_enable;
`endif
        end
        ARB: if (gnt_vld) begin
          perform_read_q <= 1'b1;
          read_address_q <= {gnt_idx, lidx_q[gnt_idx][IDX_W-1:0]};
          cur_q          <= gnt_idx;
          cur_oh_q       <= gnt;
          tmr_q          <= '0;
          state_q        <= WAIT;
        end else if (all_done) begin
          gap_q   <= '0;
          state_q <= GAP;
        end
        // A timed-out read still loads a dark pixel so the strip keeps its length.
        WAIT: if (read_data_ready || tmr_q == TMR_W'(READ_TIMEOUT - 1)) begin
          encoder_data_q <= read_data_ready ? read_data : '0;
          if (!read_data_ready) read_error_q <= 1'b1;
          encoder_load_q <= cur_oh_q;
          ch_idle_q      <= (ch_idle_q | encoder_finished) & ~cur_oh_q;
          lidx_q[cur_q]  <= lidx_q[cur_q] + LIDX_W'(1);
          rr_ptr_q       <= cur_q + CH_W'(1);
          state_q        <= ARB;
        end else begin
          tmr_q <= tmr_q + TMR_W'(1);
        end
        GAP: if (gap_q == GAP_W'(RESET_CYCLES - 1)) begin
          state_q        <= IDLE;
          frame_active_q <= 1'b0;
        end else begin
          gap_q <= gap_q + GAP_W'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign perform_read = perform_read_q;
  assign read_address = read_address_q;
  assign encoder_data = encoder_data_q;
  assign encoder_load = encoder_load_q;
  assign frame_active = frame_active_q;
  assign overrun      = overrun_q;
  assign read_error   = read_error_q;
endmodule

// File: tb/tb_strip_scheduler.sv
// Directed + randomized bench for strip_scheduler with memory and encoder models.
module tb_strip_scheduler;
  localparam int LC = 2;
  localparam int RC = 40;
  localparam int RT = 15;

  logic        clk = 1'b0, rst_n = 1'b0, framerate = 1'b0;
  logic [3:0]  encoder_finished = '0;
  logic        read_data_ready = 1'b0;
  logic [23:0] read_data = '0;
  logic        perform_read, frame_active, overrun, read_error;
  logic [8:0]  read_address;
  logic [23:0] encoder_data;
  logic [3:0]  encoder_load;
`ifdef STRIP_SCHEDULER_CHANNEL_MASK_EN
  logic [3:0]  channel_enable = 4'hF;
`endif

  strip_scheduler #(.LED_COUNT(LC), .RESET_CYCLES(RC), .READ_TIMEOUT(RT)) dut (
    .clock_12mhz      (clk),
    .reset_n          (rst_n),
    .framerate        (framerate),
    .encoder_finished (encoder_finished),
    .read_data_ready  (read_data_ready),
    .read_data        (read_data),
`ifdef STRIP_SCHEDULER_CHANNEL_MASK_EN
    .channel_enable   (channel_enable),
`endif
    .perform_read     (perform_read),
    .read_address     (read_address),
    .encoder_data     (encoder_data),
    .encoder_load     (encoder_load),
    .frame_active     (frame_active),
    .overrun          (overrun),
    .read_error       (read_error)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  initial forever begin @(posedge clk); cyc++; end

  // Transaction log of every read strobe and every encoder load.
  logic [8:0]  rd_addr[$];
  int          rd_cyc[$];
  logic [3:0]  ld_oh[$];
  logic [23:0] ld_dat[$];
  int          ld_cyc[$];
  initial forever begin
    @(negedge clk);
    if (perform_read) begin rd_addr.push_back(read_address); rd_cyc.push_back(cyc); end
    if (|encoder_load) begin ld_oh.push_back(encoder_load); ld_dat.push_back(encoder_data); ld_cyc.push_back(cyc); end
  end

  // Memory model: fixed or random latency, one address may be withheld, optional idle noise.
  logic [23:0] mem_seed;
  bit          lat_rand, hold_en, noise;
  logic [8:0]  hold_addr;
  bit          pend;
  int          mcnt;
  logic [8:0]  paddr;
  function automatic logic [23:0] mem_word(input logic [8:0] a);
    return {a, a[7:0], a[6:0]} ^ mem_seed;
  endfunction
  initial forever begin
    @(negedge clk);
    read_data_ready = 1'b0;
    if (!rst_n) pend = 1'b0;
    if (pend) begin
      mcnt--;
      if (mcnt == 0) begin read_data_ready = 1'b1; read_data = mem_word(paddr); pend = 1'b0; end
    end else if (noise) begin
      read_data_ready = 1'b1; read_data = 24'($urandom);
    end
    if (perform_read) begin
      paddr = read_address;
      mcnt  = lat_rand ? int'($urandom_range(1, 4)) : 1;
      pend  = !(hold_en && read_address == hold_addr);
    end
  end

  // Encoder model: finishes a fixed or random number of cycles after each load.
  bit [3:0] busy = '0;
  int       ecnt[4];
  int       enc_delay[4];
  bit       enc_rand;
  int       viol = 0, last_fin = 0;
  initial forever begin
    @(negedge clk);
    encoder_finished = '0;
    if (!rst_n) busy = '0;
    for (int c = 0; c < 4; c++) begin
      if (busy[c]) begin
        ecnt[c]--;
        if (ecnt[c] == 0) begin encoder_finished[c] = 1'b1; busy[c] = 1'b0; last_fin = cyc; end
      end
      if (encoder_load[c] && rst_n) begin
        if (busy[c]) viol++;
        busy[c] = 1'b1;
        ecnt[c] = enc_rand ? int'($urandom_range(1, 30)) : enc_delay[c];
      end
    end
  end

  int n_assert = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] rd_at(input int i);
    return (i < rd_addr.size()) ? rd_addr[i] : 9'h1FF;
  endfunction
  function automatic int rdc_at(input int i);
    return (i < rd_cyc.size()) ? rd_cyc[i] : -100000;
  endfunction
  function automatic int ldc_at(input int i);
    return (i < ld_cyc.size()) ? ld_cyc[i] : -100000;
  endfunction

  task automatic tick();
    @(negedge clk); framerate = 1'b1;
    @(negedge clk); framerate = 1'b0;
  endtask

  task automatic wait_fall(input string tag, output int fall);
    fall = -1;
    for (int k = 0; k < 6000; k++) begin
      @(negedge clk);
      if (!frame_active) begin fall = cyc; break; end
    end
    chk({tag, " frame ends"}, 32'(fall >= 0), 1);
  endtask

  // Scoreboard: each enabled channel walks 0..LC-1 once in order, loads follow reads 1:1.
  task automatic check_frame(input string tag, input int br, input int bl, input logic [3:0] en);
    int nexp;
    int nxt[4];
    logic [8:0]  a;
    logic [23:0] e;
    nexp = LC * $countones(en);
    for (int c = 0; c < 4; c++) nxt[c] = 0;
    chk({tag, " reads"}, rd_addr.size() - br, nexp);
    chk({tag, " loads"}, ld_oh.size() - bl, nexp);
    for (int i = 0; i < nexp && br + i < rd_addr.size() && bl + i < ld_oh.size(); i++) begin
      a = rd_addr[br + i];
      chk({tag, " ch enabled"}, 32'(en[a[8:7]]), 1);
      chk({tag, " led order"}, a[6:0], nxt[a[8:7]]);
      nxt[a[8:7]]++;
      chk({tag, " load ch"}, ld_oh[bl + i], 4'b0001 << a[8:7]);
      e = (hold_en && a == hold_addr) ? 24'h000000 : mem_word(a);
      chk({tag, " load data"}, ld_dat[bl + i], e);
    end
    chk({tag, " grant to busy ch"}, viol, 0);
  endtask

  // With fast encoders every channel is idle again by its turn, so grants rotate strictly.
  task automatic check_rr(input string tag, input int br, input int first_ch);
    int ch;
    for (int i = 0; i < 4 * LC; i++) begin
      ch = (first_ch + i) % 4;
      chk({tag, " rr order"}, rd_at(br + i), {2'(ch), 7'(i / 4)});
    end
  endtask

  int  br, bl, fall;
  bit  ok;
  initial begin
    mem_seed = 24'($urandom);
    lat_rand = 0; hold_en = 0; hold_addr = '0; noise = 0; enc_rand = 0;
    for (int c = 0; c < 4; c++) enc_delay[c] = 5;
    repeat (3) @(negedge clk);
    chk("rst perform_read", perform_read, 0);
    chk("rst read_address", read_address, 0);
    chk("rst encoder_data", encoder_data, 0);
    chk("rst encoder_load", encoder_load, 0);
    chk("rst frame_active", frame_active, 0);
    chk("rst overrun", overrun, 0);
    chk("rst read_error", read_error, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Ready pulses while idle must not produce loads.
    noise = 1; repeat (8) @(negedge clk); noise = 0; @(negedge clk);
    chk("idle noise loads", ld_oh.size(), 0);
    chk("idle noise reads", rd_addr.size(), 0);
    chk("idle noise active", frame_active, 0);

    // Frame 1: strict round robin, then a dropped tick during the gap.
    br = rd_addr.size(); bl = ld_oh.size();
    tick();
    chk("t1 frame_active", frame_active, 1);
    ok = 0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (ld_oh.size() - bl >= 4 * LC && busy == 0) begin ok = 1; break; end
    end
    chk("t1 loads drained", 32'(ok), 1);
    chk("t1 overrun before", overrun, 0);
    repeat (4) @(negedge clk);
    tick();
    chk("t1 overrun", overrun, 1);
    chk("t1 active in gap", frame_active, 1);
    wait_fall("t1", fall);
    chk("t1 gap length", fall - last_fin, RC + 2);
    check_frame("t1", br, bl, 4'hF);
    check_rr("t1", br, 0);
    chk("t1 latency", ldc_at(bl) - rdc_at(br), 2);
    chk("t1 read_error", read_error, 0);
    repeat (10) @(negedge clk);
    chk("t1 dropped tick reads", rd_addr.size() - br, 4 * LC);
    chk("t1 dropped tick idle", frame_active, 0);

    // Frame 2: channel 2 encoder is slow; others keep flowing.
    enc_delay[2] = 200;
    br = rd_addr.size(); bl = ld_oh.size();
    tick();
    wait_fall("t2", fall);
    check_frame("t2", br, bl, 4'hF);
    chk("t2 first addr", rd_at(br), 9'h000);
    chk("t2 last addr", rd_at(br + 7), 9'h101);
    chk("t2 ch2 held", 32'(rdc_at(br + 7) - ldc_at(bl + 2) > 200), 1);
    enc_delay[2] = 5;

    // Frame 3: address 0x081 never answers.
    hold_en = 1; hold_addr = 9'h081;
    br = rd_addr.size(); bl = ld_oh.size();
    tick();
    wait_fall("t3", fall);
    check_frame("t3", br, bl, 4'hF);
    chk("t3 first addr", rd_at(br), 9'h180);
    chk("t3 read_error", read_error, 1);
    hold_en = 0;

    // Randomized frames: memory latency, encoder delays and contents.
    enc_rand = 1; lat_rand = 1;
    for (int f = 0; f < 3; f++) begin
      mem_seed = 24'($urandom);
      br = rd_addr.size(); bl = ld_oh.size();
      tick();
      wait_fall("rand", fall);
      check_frame("rand", br, bl, 4'hF);
    end
    enc_rand = 0; lat_rand = 0;

    // Reset while waiting on memory.
    tick();
    ok = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (perform_read) begin ok = 1; break; end
    end
    chk("t5 reached wait", 32'(ok), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5 perform_read", perform_read, 0);
    chk("t5 encoder_load", encoder_load, 0);
    chk("t5 frame_active", frame_active, 0);
    chk("t5 read_address", read_address, 0);
    chk("t5 overrun", overrun, 0);
    chk("t5 read_error", read_error, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    br = rd_addr.size(); bl = ld_oh.size();
    repeat (20) @(negedge clk);
    chk("t5 quiet reads", rd_addr.size() - br, 0);
    chk("t5 quiet loads", ld_oh.size() - bl, 0);
    chk("t5 quiet active", frame_active, 0);
    tick();
    wait_fall("t5", fall);
    check_frame("t5", br, bl, 4'hF);
    check_rr("t5", br, 0);

`ifdef STRIP_SCHEDULER_CHANNEL_MASK_EN
    channel_enable = 4'b0101;
    br = rd_addr.size(); bl = ld_oh.size();
    tick();
    channel_enable = 4'b1111;
    wait_fall("m5", fall);
    check_frame("m5", br, bl, 4'b0101);
    channel_enable = 4'b0000;
    br = rd_addr.size(); bl = ld_oh.size();
    tick();
    channel_enable = 4'b1111;
    wait_fall("m0", fall);
    check_frame("m0", br, bl, 4'b0000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/strip_scheduler.md
Name: strip_scheduler

Overview:
Sequences frame refresh for the four RJ-45 strip channels (j1..j4), which share the single LED memory read port. On each framerate tick it walks every channel's LED list. It arbitrates memory reads round-robin among channels whose xx6812 encoder is idle, and hands each fetched 24-bit word to the owning encoder. It then holds the strip reset/latch gap before accepting the next frame.

Parameters:
LED_COUNT, 128, LEDs per channel (1..128); memory address = {channel[1:0], led_index[6:0]}
RESET_CYCLES, 1000, clock_12mhz cycles of idle line after frame (>=80 us latch)
READ_TIMEOUT, 15, max cycles from perform_read to read_data_ready before the read is abandoned

Ports:
clock_12mhz  input  1  system clock
reset_n  input  1  asynchronous, active-low reset
framerate  input  1  one-cycle frame-start pulse, clock_12mhz domain
encoder_finished  input  4  per-channel one-cycle done pulse from encoder_xx6812
read_data_ready  input  1  memory read data valid pulse
read_data  input  24  memory read data
perform_read  output  1  one-cycle memory read strobe
read_address  output  9  {channel, led_index}, stable from perform_read until data/timeout
encoder_data  output  24  registered word for the loaded channel
encoder_load  output  4  one-hot one-cycle load/counter_reset pulse to channel encoder
frame_active  output  1  high from accepted tick until reset gap ends
overrun  output  1  sticky: tick arrived while frame_active
read_error  output  1  sticky: a read timed out

Behaviour:
- Reset (async, reset_n=0): all outputs 0; state IDLE; led_index[c]=0; ch_idle=4'b1111; rr_ptr=0; timers 0. Sticky flags are cleared only by reset.
- State IDLE: on framerate go to ARB; frame_active<=1; led_index[*]<=0.
- State ARB: req[c] = ch_idle[c] & (led_index[c] < LED_COUNT). Grant the first set req, searching from rr_ptr upward mod 4. On grant: perform_read=1 for one cycle; read_address<={c, led_index[c]}; go WAIT. No req and all channels complete (led_index==LED_COUNT and ch_idle all 1): go GAP. Otherwise stay.
- State WAIT: on read_data_ready, encoder_data<=read_data and encoder_load[c]=1 on the next cycle. Then ch_idle[c]<=0, led_index[c]++, rr_ptr<=c+1 mod 4, back to ARB. If READ_TIMEOUT cycles pass with no ready: read_error<=1, encoder_data<=24'h000000, load proceeds as normal (the LED is dark, not skipped, so strip length is preserved).
- Latency: perform_read to encoder_load = memory latency + 1 cycle. Minimum grant-to-grant spacing is 3 cycles.
- encoder_finished[c] sets ch_idle[c] in any state. A pulse on a channel that is already idle is ignored. If finished[c] and a grant to c would coincide, the grant occurs next cycle (ch_idle registered).
- State GAP: counter runs 0..RESET_CYCLES-1, then IDLE; frame_active<=0 on exit.
- framerate while frame_active (ARB/WAIT/GAP): overrun<=1 and the tick is dropped, not queued.
- read_data_ready outside WAIT is ignored.
- led_index width is 8 bits so LED_COUNT=128 is reachable without wrap. Address uses bits [6:0].
- Memory write port is independent; the scheduler never blocks UART writes.
- Reset mid-frame: immediate return to IDLE. The encoders share reset_n and restart cleanly.

Optional Feature:
STRIP_SCHEDULER_CHANNEL_MASK_EN
- With macro: adds input channel_enable[3:0], sampled on the accepted framerate tick and held for the frame. Disabled channels never request, are treated as complete, and receive no encoder_load. An all-zero mask completes the frame directly into GAP.
- Without macro: all four channels are always enabled; port absent.

Decomposition:
- Shared package strip_pkg holds: NUM_CHANNELS=4, CH_W=2, IDX_W=7, ADDR_W=9, PIXEL_W=24, and the state enum {IDLE, ARB, WAIT, GAP}.
- Natural sub-module rr_arbiter4: 4-bit req, rr_ptr in, one-hot grant plus encoded index out; purely combinational, reusable.

Test Plan:
- LED_COUNT=2, memory model latency 1, encoders finish 5 cycles after load, one tick -> 8 reads, addresses 0x000,0x080,0x100,0x180,0x001,0x081,0x101,0x181; encoder_load one-hot matches channel; frame_active drops RESET_CYCLES after last finish.
- Channel 2 encoder finishes slowly (200 cycles) -> channels 0,1,3 keep being served; channel 2 not re-granted until its finished pulse; no address repeated.
- Tick during GAP -> overrun=1, no new reads; next tick after IDLE starts frame normally with led_index=0.
- Memory withholds read_data_ready on address 0x081 -> after 15 cycles read_error=1, encoder_data=0x000000 loaded to channel 1, sequence continues at next grant.
- reset_n pulled low during WAIT -> perform_read, encoder_load, frame_active=0 asynchronously; after release, no activity until next tick.
- With STRIP_SCHEDULER_CHANNEL_MASK_EN, channel_enable=4'b0101 -> only addresses 0x0xx and 0x1xx read; encoder_load[1] and [3] never pulse; mask 4'b0000 -> straight to GAP.
